// File: rtl/scope_trig_capture.sv
// scope_trig_capture: edge-triggered capture of a filtered sample stream.
// Each capture records DEPTH samples into a circular buffer: PRETRIG samples
// before the trigger sample, the trigger sample, and DEPTH-PRETRIG-1 after it.
// The window is read back through a registered random-access port.
// Optional feature macro: TRIG_TIMEOUT_EN (auto-trigger after TIMEOUT samples
// in WAIT_TRIG; when undefined no counter is built and auto_trig is tied 0).
module scope_trig_capture #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int DEPTH     = 256,
    parameter int PRETRIG   = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [DATA_SIZE-1:0] trig_level,
    input  logic                 trig_slope,
    input  logic [DATA_SIZE-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 triggered,
    output logic                 capture_done,
    output logic                 auto_trig,
    output logic [2:0]           state_dbg
);

    // Handshake: sample_valid is a one-cycle strobe with no back-pressure;
    // every cycle it is high during PRE/WAIT_TRIG/POST one sample is consumed.
    // arm is a single-cycle request honoured only in IDLE or DONE.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] prev;
    logic [ADDR_SIZE-1:0] wptr, cnt, trig_ptr, start_ptr, rd_phys;
    logic [ADDR_SIZE:0]   rd_sum, rd_sum_w;
    logic capturing, wr_en, arm_ok, pre_last, post_last;
    logic real_hit, time_hit, trig_hit, trig_q;

`ifdef TRIG_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;
    logic          auto_q;
`endif

    // Decode the current state into write/trigger qualifiers.
    always_comb begin
        capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
        wr_en     = capturing && sample_valid;
        arm_ok    = arm && ((state == S_IDLE) || (state == S_DONE));
        pre_last  = (cnt == ADDR_SIZE'(PRETRIG - 1));
        post_last = (cnt == ADDR_SIZE'(DEPTH - PRETRIG - 2));
        real_hit  = 1'b0;
        if (trig_slope)
            real_hit = (prev > trig_level) && (sample_in <= trig_level);
        else
            real_hit = (prev < trig_level) && (sample_in >= trig_level);
`ifdef TRIG_TIMEOUT_EN
        time_hit = (tcnt == TW'(TIMEOUT - 1));
`else
        time_hit = 1'b0;
`endif
        trig_hit = (state == S_WAIT) && sample_valid && (real_hit || time_hit);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (arm_ok) state_nx = S_PRE;
            S_PRE:          if (sample_valid && pre_last) state_nx = S_WAIT;
            S_WAIT:         if (trig_hit) state_nx = S_POST;
            S_POST:         if (sample_valid && post_last) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Pointers, counters, previous sample and trigger flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            cnt      <= '0;
            prev     <= '0;
            trig_ptr <= '0;
            trig_q   <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
            tcnt     <= '0;
            auto_q   <= 1'b0;
`endif
        end else if (arm_ok) begin
            wptr   <= '0;
            cnt    <= '0;
            trig_q <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
            tcnt   <= '0;
            auto_q <= 1'b0;
`endif
        end else if (wr_en) begin
            wptr <= (wptr == ADDR_SIZE'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            prev <= sample_in;
            case (state)
                S_PRE:  cnt <= pre_last ? '0 : cnt + 1'b1;
                S_WAIT: begin
`ifdef TRIG_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
`endif
                    if (trig_hit) begin
                        trig_ptr <= wptr;
                        trig_q   <= 1'b1;
                        cnt      <= '0;
`ifdef TRIG_TIMEOUT_EN
                        auto_q   <= ~real_hit;
`endif
                    end
                end
                S_POST:  cnt <= cnt + 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sample buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= sample_in;
    end

    // Map the logical read index onto the circular buffer.
    always_comb begin
        if (trig_ptr >= ADDR_SIZE'(PRETRIG))
            start_ptr = trig_ptr - ADDR_SIZE'(PRETRIG);
        else
            start_ptr = trig_ptr + ADDR_SIZE'(DEPTH - PRETRIG);
        rd_sum   = {1'b0, start_ptr} + {1'b0, rd_addr};
        rd_sum_w = rd_sum;
        if (rd_sum >= (ADDR_SIZE + 1)'(DEPTH))
            rd_sum_w = rd_sum - (ADDR_SIZE + 1)'(DEPTH);
        rd_phys = rd_sum_w[ADDR_SIZE-1:0];
    end

    // Registered readout.
    always_ff @(posedge clk) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_phys];
    end

    assign busy         = capturing;
    assign triggered    = trig_q;
    assign capture_done = (state == S_DONE);
    assign state_dbg    = state;
`ifdef TRIG_TIMEOUT_EN
    assign auto_trig    = auto_q;
`else
    assign auto_trig    = 1'b0;
`endif

endmodule
